// File: rtl/vball_pkg.sv
// Shared constants for the sprite DMA: RAM geometry, sprite byte layout and DMA state codes.
package vball_pkg;

    localparam int unsigned SPR_RAM_DEPTH       = 256;
    localparam int unsigned SPR_BYTES_PER_ENTRY = 4;

    localparam logic [1:0] SPR_Y    = 2'd0;
    localparam logic [1:0] SPR_ATTR = 2'd1;
    localparam logic [1:0] SPR_ID   = 2'd2;
    localparam logic [1:0] SPR_X    = 2'd3;

    localparam logic [8:0] SPR_START_LINE = 9'd240;

    typedef logic [1:0] dma_state_t;
    localparam dma_state_t DMA_IDLE  = 2'd0;
    localparam dma_state_t DMA_RUN   = 2'd1;
    localparam dma_state_t DMA_FLUSH = 2'd2;

endpackage

// File: rtl/vball_dpram.sv
// Byte-wide simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero; the array itself is not reset.
module vball_dpram
    import vball_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on an address collision: rdata sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/vball_sprite_dma.sv
// Sprite RAM with a vblank-time copy into a shadow RAM read by the line renderer.
// Define SPR_DMA_CPU_TRIG_EN to start the copy from a dma_req strobe instead of vcount.
module vball_sprite_dma
    import vball_pkg::*;
#(
    parameter logic [8:0]  START_LINE = SPR_START_LINE,
    parameter int unsigned AW         = 8
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic [8:0]    vcount,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    input  logic [AW-1:0] sma,
    output logic [7:0]    smd,
    output logic          dma_busy
`ifdef SPR_DMA_CPU_TRIG_EN
    ,
    input  logic          dma_req
`endif
);

    dma_state_t    state;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          trig;
    logic          cpu_wr;
    logic [7:0]    copy_data;

    assign cpu_wr = cpu_cs & cpu_we;

`ifdef SPR_DMA_CPU_TRIG_EN
    assign trig = dma_req;
`else
    logic [8:0] vcl;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            vcl <= 9'd0;
        end else begin
            vcl <= vcount;
        end
    end

    // One pulse on the first cycle of the start line.
    assign trig = (vcount != vcl) && (vcount == START_LINE);
`endif

    // Triggers arriving outside IDLE are dropped, so a busy copy never restarts.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DMA_IDLE;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_en    <= 1'b0;
            dma_busy <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                DMA_IDLE: begin
                    if (trig) begin
                        rd_addr  <= '0;
                        dma_busy <= 1'b1;
                        state    <= DMA_RUN;
                    end
                end
                DMA_RUN: begin
                    wr_addr <= rd_addr;
                    wr_en   <= 1'b1;
                    if (rd_addr == '1) begin
                        state <= DMA_FLUSH;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                DMA_FLUSH: begin
                    dma_busy <= 1'b0;
                    state    <= DMA_IDLE;
                end
                default: begin
                    state <= DMA_IDLE;
                end
            endcase
        end
    end

    // CPU RAM is held as two identical copies written in lockstep, giving the
    // CPU and the copy engine independent read ports.
    vball_dpram #(.AW(AW)) u_cpu_ram (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .we    (cpu_wr),
        .waddr (cpu_addr),
        .wdata (cpu_din),
        .raddr (cpu_addr),
        .rdata (cpu_dout)
    );

    vball_dpram #(.AW(AW)) u_copy_ram (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .we    (cpu_wr),
        .waddr (cpu_addr),
        .wdata (cpu_din),
        .raddr (rd_addr),
        .rdata (copy_data)
    );

    vball_dpram #(.AW(AW)) u_shadow_ram (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (copy_data),
        .raddr (sma),
        .rdata (smd)
    );

endmodule

// File: tb/tb_vball_sprite_dma.sv
// Directed bench for vball_sprite_dma: vector table plus multi-cycle copy sequences.
module tb_vball_sprite_dma;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic [8:0] vcount;
    logic       cpu_cs;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic [7:0] sma;
    logic [7:0] smd;
    logic       dma_busy;
`ifdef SPR_DMA_CPU_TRIG_EN
    logic       dma_req;
`endif

    always #5 clk_sys = ~clk_sys;

    vball_sprite_dma u_dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .vcount   (vcount),
        .cpu_cs   (cpu_cs),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .sma      (sma),
        .smd      (smd),
        .dma_busy (dma_busy)
`ifdef SPR_DMA_CPU_TRIG_EN
        ,
        .dma_req  (dma_req)
`endif
    );

    typedef struct {
        bit         cpu_port;
        logic [7:0] addr;
        logic [7:0] exp;
    } vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] cpu_mem [256];
    logic [7:0] sh      [256];
    int         inj_cyc  [3];
    logic [7:0] inj_addr [3];
    logic [7:0] inj_data [3];

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        cpu_cs   = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_din  = d;
        tick();
        cpu_cs   = 1'b0;
        cpu_we   = 1'b0;
        cpu_mem[a] = d;
    endtask

    task automatic read_shadow(input logic [7:0] a, output logic [7:0] d);
        sma = a;
        tick();
        d = smd;
    endtask

    task automatic sweep_shadow(input string tag);
        logic [7:0] d;
        for (int a = 0; a < 256; a++) begin
            read_shadow(a[7:0], d);
            check($sformatf("%s shadow[%02h]", tag, a), {24'd0, d}, {24'd0, sh[a]});
        end
    endtask

    // Cycle 0 is the trigger cycle; busy is counted over a fixed 300-cycle window.
    task automatic run_copy(input int glitch_at, input int n_inj, output int busy_cnt);
        vcount = 9'd239;
        tick();
        busy_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            cpu_cs = 1'b0;
            cpu_we = 1'b0;
            vcount = (c == glitch_at) ? 9'd241 : 9'd240;
`ifdef SPR_DMA_CPU_TRIG_EN
            dma_req = (c == 0) || (c == glitch_at);
`endif
            for (int j = 0; j < n_inj; j++) begin
                if (inj_cyc[j] == c) begin
                    cpu_cs   = 1'b1;
                    cpu_we   = 1'b1;
                    cpu_addr = inj_addr[j];
                    cpu_din  = inj_data[j];
                end
            end
            tick();
            if (dma_busy) busy_cnt++;
        end
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
`ifdef SPR_DMA_CPU_TRIG_EN
        dma_req = 1'b0;
`endif
    endtask

    initial begin
        vec_t       vecs [10];
        int         busy_cnt;
        logic [7:0] d;

        vecs[0] = '{1'b1, 8'h00, 8'h5A};
        vecs[1] = '{1'b1, 8'h10, 8'h4A};
        vecs[2] = '{1'b1, 8'hFF, 8'hA5};
        vecs[3] = '{1'b0, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 8'h10, 8'h4A};
        vecs[5] = '{1'b0, 8'h5A, 8'h00};
        vecs[6] = '{1'b0, 8'hFF, 8'hA5};
        vecs[7] = '{1'b0, 8'h80, 8'hDA};
        vecs[8] = '{1'b0, 8'h01, 8'h5B};
        vecs[9] = '{1'b0, 8'h3C, 8'h66};

        rst_n    = 1'b0;
        vcount   = 9'd0;
        cpu_cs   = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 8'h00;
        cpu_din  = 8'h00;
        sma      = 8'h00;
`ifdef SPR_DMA_CPU_TRIG_EN
        dma_req  = 1'b0;
`endif
        tick();
        tick();
        check("reset dma_busy", {31'd0, dma_busy}, 32'd0);
        check("reset smd", {24'd0, smd}, 32'd0);
        check("reset cpu_dout", {24'd0, cpu_dout}, 32'd0);
        rst_n = 1'b1;
        vcount = 9'd100;
        tick();

        for (int i = 0; i < 256; i++) cpu_write(i[7:0], i[7:0] ^ 8'h5A);
        check("no copy before start line", {31'd0, dma_busy}, 32'd0);

`ifdef SPR_DMA_CPU_TRIG_EN
        vcount = 9'd239;
        tick();
        vcount = 9'd240;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (dma_busy) busy_cnt++;
        end
        check("vcount trigger disabled", busy_cnt, 0);
`endif

        run_copy(-1, 0, busy_cnt);
        check("basic copy busy cycles", busy_cnt, 257);
        sh = cpu_mem;

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].cpu_port) begin
                cpu_addr = vecs[i].addr;
                tick();
                d = cpu_dout;
            end else begin
                read_shadow(vecs[i].addr, d);
            end
            check($sformatf("vec%0d %s[%02h]", i, vecs[i].cpu_port ? "cpu" : "shadow",
                            vecs[i].addr), {24'd0, d}, {24'd0, vecs[i].exp});
        end

        // Frame isolation: a mid-frame CPU write is invisible until the next copy.
        vcount = 9'd100;
        tick();
        cpu_write(8'h05, 8'h77);
        read_shadow(8'h05, d);
        check("isolation before copy", {24'd0, d}, 32'h5F);
        run_copy(-1, 0, busy_cnt);
        check("isolation copy busy", busy_cnt, 257);
        sh = cpu_mem;
        read_shadow(8'h05, d);
        check("isolation after copy", {24'd0, d}, 32'h77);

        // Writes during the copy: 02 already read, 20 collides with its read, F0 not yet read.
        inj_cyc[0] = 10; inj_addr[0] = 8'h02; inj_data[0] = 8'hBB;
        inj_cyc[1] = 11; inj_addr[1] = 8'hF0; inj_data[1] = 8'hAA;
        inj_cyc[2] = 33; inj_addr[2] = 8'h20; inj_data[2] = 8'hCC;
        run_copy(-1, 3, busy_cnt);
        check("mid-copy busy", busy_cnt, 257);
        sh = cpu_mem;
        sh[8'hF0] = 8'hAA;
        cpu_mem[8'h02] = 8'hBB;
        cpu_mem[8'h20] = 8'hCC;
        cpu_mem[8'hF0] = 8'hAA;
        read_shadow(8'hF0, d);
        check("late write copied", {24'd0, d}, 32'hAA);
        read_shadow(8'h02, d);
        check("early write deferred", {24'd0, d}, 32'h58);
        read_shadow(8'h20, d);
        check("read-before-write", {24'd0, d}, 32'h7A);
        cpu_addr = 8'h02;
        tick();
        check("cpu ram holds early write", {24'd0, cpu_dout}, 32'hBB);
        sweep_shadow("midcopy");

        run_copy(50, 0, busy_cnt);
        check("retrigger single window", busy_cnt, 257);
        sh = cpu_mem;
        sweep_shadow("retrig");

        // Reset mid-copy leaves the shadow partly updated.
        vcount = 9'd100;
        tick();
        for (int i = 0; i < 256; i++) cpu_write(i[7:0], i[7:0] ^ 8'hC3);
        vcount = 9'd239;
        tick();
        vcount = 9'd240;
`ifdef SPR_DMA_CPU_TRIG_EN
        dma_req = 1'b1;
        tick();
        dma_req = 1'b0;
        repeat (99) tick();
`else
        repeat (100) tick();
`endif
        check("busy before reset", {31'd0, dma_busy}, 32'd1);
        rst_n  = 1'b0;
        vcount = 9'd100;
        #1;
        check("mid-copy reset busy", {31'd0, dma_busy}, 32'd0);
        check("mid-copy reset smd", {24'd0, smd}, 32'd0);
        check("mid-copy reset cpu_dout", {24'd0, cpu_dout}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (dma_busy) busy_cnt++;
        end
        check("idle after reset release", busy_cnt, 0);
        read_shadow(8'h10, d);
        check("partial copy new byte", {24'd0, d}, 32'hD3);
        read_shadow(8'hE0, d);
        check("partial copy old byte", {24'd0, d}, 32'hBA);

        run_copy(-1, 0, busy_cnt);
        check("copy after reset busy", busy_cnt, 257);
        sh = cpu_mem;
        sweep_shadow("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
